// File: rtl/iic_cfg_seq_if.sv
// Handshake bundle between the configuration sequencer (master) and the I2C byte driver (slave).
interface iic_cfg_seq_if #(
  parameter logic [1:0] ADDR_BYTE = 2'd1
) ();
  logic                   iic_pluse;
  logic [7:0]             iic_device_id;
  logic                   iic_w_r;
  logic [3:0]             iic_byte_len;
  logic [ADDR_BYTE*8-1:0] iic_addr;
  logic [7:0]             iic_data_in;
  logic                   iic_busy;
  logic                   iic_byte_over;
  logic [7:0]             iic_data_out;

  modport master (
    output iic_pluse, iic_device_id, iic_w_r, iic_byte_len, iic_addr, iic_data_in,
    input  iic_busy, iic_byte_over, iic_data_out
  );

  modport slave (
    input  iic_pluse, iic_device_id, iic_w_r, iic_byte_len, iic_addr, iic_data_in,
    output iic_busy, iic_byte_over, iic_data_out
  );
endinterface

// File: rtl/iic_cfg_seq.sv
// Walks a register table and issues one I2C write per entry after a power-up delay.
// Optional feature macro CFG_READBACK_EN: read each register back and count mismatches.
module iic_cfg_seq #(
  parameter logic [7:0]  REG_NUM   = 8'd16,
  parameter logic [1:0]  ADDR_BYTE = 2'd1,
  parameter logic [7:0]  DEVICE_ID = 8'h78,
  parameter logic [23:0] INIT_DLY  = 24'd1000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_start,
  output logic [7:0]             tbl_idx,
  input  logic [ADDR_BYTE*8+7:0] tbl_data,
  iic_cfg_seq_if.master          iic,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [7:0]             err_cnt
);
  localparam int AW = int'(ADDR_BYTE) * 8;
  localparam int DW = AW + 8;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PWR_DLY = 4'd1,
    S_LOAD    = 4'd2,
    S_TRIG    = 4'd3,
    S_WAIT    = 4'd4,
    S_NEXT    = 4'd5,
`ifdef CFG_READBACK_EN
    S_RD_TRIG = 4'd6,
    S_RD_WAIT = 4'd7,
    S_CMP     = 4'd8,
`endif
    S_DONE    = 4'd9
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [7:0]      idx_r, idx_nxt_s;
  logic [23:0]     cnt_r, cnt_nxt_s;
  logic            pluse_r, pluse_nxt_s;
  logic            wr_r, wr_nxt_s;
  logic [AW-1:0]   addr_r, addr_nxt_s;
  logic [7:0]      wdata_r, wdata_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            done_r, done_nxt_s;
  logic            err_r, err_nxt_s;
  logic [7:0]      err_cnt_r, err_cnt_nxt_s;
`ifdef CFG_READBACK_EN
  logic [7:0]      rdata_r, rdata_nxt_s;
`else
  logic            unused_s;
  assign unused_s = ^{iic.iic_byte_over, iic.iic_data_out};
`endif

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    cnt_nxt_s     = cnt_r;
    pluse_nxt_s   = pluse_r;
    wr_nxt_s      = wr_r;
    addr_nxt_s    = addr_r;
    wdata_nxt_s   = wdata_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = done_r;
    err_nxt_s     = err_r;
    err_cnt_nxt_s = err_cnt_r;
`ifdef CFG_READBACK_EN
    rdata_nxt_s   = rdata_r;
`endif
    case (state_r)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          state_nxt_s = S_PWR_DLY;
          idx_nxt_s   = 8'd0;
          cnt_nxt_s   = 24'd0;
          busy_nxt_s  = 1'b1;
          done_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_PWR_DLY: begin
        cnt_nxt_s = cnt_r + 24'd1;
        if (cnt_r == INIT_DLY - 24'd1) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_PWR_DLY;
        end
      end
      S_LOAD: begin
        if (!iic.iic_busy) begin
          addr_nxt_s  = tbl_data[DW-1:8];
          wdata_nxt_s = tbl_data[7:0];
          wr_nxt_s    = 1'b1;
          pluse_nxt_s = 1'b1;
          state_nxt_s = S_TRIG;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_TRIG: begin
        if (iic.iic_busy) begin
          pluse_nxt_s = 1'b0;
          state_nxt_s = S_WAIT;
        end else begin
          pluse_nxt_s = 1'b1;
        end
      end
      S_WAIT: begin
        if (!iic.iic_busy) begin
`ifdef CFG_READBACK_EN
          // pluse was low throughout WAIT, so re-raising it here keeps the minimum gap
          wr_nxt_s    = 1'b0;
          pluse_nxt_s = 1'b1;
          state_nxt_s = S_RD_TRIG;
`else
          state_nxt_s = S_NEXT;
`endif
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
`ifdef CFG_READBACK_EN
      S_RD_TRIG: begin
        if (iic.iic_busy) begin
          pluse_nxt_s = 1'b0;
          state_nxt_s = S_RD_WAIT;
        end else begin
          pluse_nxt_s = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (iic.iic_byte_over) begin
          rdata_nxt_s = iic.iic_data_out;
        end else begin
          rdata_nxt_s = rdata_r;
        end
        if (!iic.iic_busy) begin
          state_nxt_s = S_CMP;
        end else begin
          state_nxt_s = S_RD_WAIT;
        end
      end
      S_CMP: begin
        if (rdata_r != tbl_data[7:0]) begin
          err_nxt_s = 1'b1;
          if (err_cnt_r != 8'hFF) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
          end else begin
            err_cnt_nxt_s = err_cnt_r;
          end
        end else begin
          err_nxt_s = err_r;
        end
        wr_nxt_s    = 1'b1;
        state_nxt_s = S_NEXT;
      end
`endif
      S_NEXT: begin
        if (idx_r == REG_NUM - 8'd1) begin
          state_nxt_s = S_DONE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          idx_nxt_s   = idx_r + 8'd1;
          state_nxt_s = S_LOAD;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        pluse_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= S_IDLE;
      idx_r     <= 8'd0;
      cnt_r     <= 24'd0;
      pluse_r   <= 1'b0;
      wr_r      <= 1'b1;
      addr_r    <= '0;
      wdata_r   <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= 8'd0;
`ifdef CFG_READBACK_EN
      rdata_r   <= 8'd0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pluse_r   <= pluse_nxt_s;
      wr_r      <= wr_nxt_s;
      addr_r    <= addr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
`ifdef CFG_READBACK_EN
      rdata_r   <= rdata_nxt_s;
`endif
    end
  end

  assign tbl_idx           = idx_r;
  assign iic.iic_pluse     = pluse_r;
  assign iic.iic_device_id = DEVICE_ID;
  assign iic.iic_w_r       = wr_r;
  assign iic.iic_byte_len  = 4'd1;
  assign iic.iic_addr      = addr_r;
  assign iic.iic_data_in   = wdata_r;
  assign cfg_busy          = busy_r;
  assign cfg_done          = done_r;
  assign cfg_err           = err_r;
  assign err_cnt           = err_cnt_r;
endmodule

// File: tb/tb_iic_cfg_seq.sv
// Scoreboard bench for iic_cfg_seq: random tables, a behavioural I2C driver and a REG_NUM=1 instance.
module tb_iic_cfg_seq;
  localparam logic [7:0]  RN  = 8'd3;
  localparam logic [1:0]  AB  = 2'd1;
  localparam logic [7:0]  DID = 8'h78;
  localparam logic [23:0] IDL = 24'd10;
`ifdef CFG_READBACK_EN
  localparam int XPE = 2;
`else
  localparam int XPE = 1;
`endif

  typedef struct packed {
    logic [7:0] idx;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_start = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  tbl_idx, tbl_idx1;
  logic [15:0] tbl_data, tbl_data1;
  logic        cfg_busy, cfg_done, cfg_err, busy1, done1, err1;
  logic [7:0]  err_cnt, err_cnt1;
  logic [15:0] tbl_mem [0:255];

  xfer_t       sb_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  exp_err_cnt = 8'd0;
  int          n_chk = 0;
  int          n_err = 0;
  int          pl_cnt = 0;
  int          p1_cnt = 0;
  int          busy_len = 50;
  int          stab_bad = 0;
  int          wr_bad = 0;
  int          err_bad = 0;

  iic_cfg_seq_if #(.ADDR_BYTE(AB)) ifc ();
  iic_cfg_seq_if #(.ADDR_BYTE(AB)) if1 ();

  always #5 clk = ~clk;

  assign tbl_data  = tbl_mem[tbl_idx];
  assign tbl_data1 = 16'h55A5;

  iic_cfg_seq #(.REG_NUM(RN), .ADDR_BYTE(AB), .DEVICE_ID(DID), .INIT_DLY(IDL)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .iic(ifc.master), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_cnt(err_cnt)
  );

  iic_cfg_seq #(.REG_NUM(8'd1), .ADDR_BYTE(AB), .DEVICE_ID(DID), .INIT_DLY(24'd3)) dut1 (
    .clk(clk), .rstn(rstn), .cfg_start(start1), .tbl_idx(tbl_idx1), .tbl_data(tbl_data1),
    .iic(if1.master), .cfg_busy(busy1), .cfg_done(done1), .cfg_err(err1), .err_cnt(err_cnt1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  task automatic chk_reset();
    chk("rst_idx",   64'(tbl_idx), 64'(8'd0));
    chk("rst_pluse", 64'(ifc.iic_pluse), 64'(1'b0));
    chk("rst_flags", 64'({cfg_busy, cfg_done, cfg_err}), 64'(3'b000));
    chk("rst_errcnt", 64'(err_cnt), 64'(8'd0));
    chk("rst_addr",  64'(ifc.iic_addr), 64'(8'd0));
    chk("rst_data",  64'(ifc.iic_data_in), 64'(8'd0));
    chk("rst_w_r",   64'(ifc.iic_w_r), 64'(1'b1));
  endtask

  // Reference model: one write per entry, plus a readback per entry when enabled
  task automatic push_pass(input bit first);
`ifdef CFG_READBACK_EN
    bit         bad;
    logic [7:0] rb;
`endif
    for (int i = 0; i < int'(RN); i++) begin
      if (!first) tbl_mem[i] = 16'($urandom);
      sb_q.push_back('{8'(i), 1'b1, tbl_mem[i][15:8], tbl_mem[i][7:0]});
`ifdef CFG_READBACK_EN
      bad = first ? (i == 0) : ($urandom_range(0, 3) == 0);
      rb  = tbl_mem[i][7:0];
      if (bad) rb = first ? (rb ^ 8'h01) : (rb ^ 8'(1 << $urandom_range(0, 7)));
      rd_q.push_back(rb);
      sb_q.push_back('{8'(i), 1'b0, tbl_mem[i][15:8], tbl_mem[i][7:0]});
      if (bad && exp_err_cnt != 8'hFF) exp_err_cnt++;
`endif
    end
  endtask

  task automatic run_pass(input bit first, input bit poke, input bit abort);
    int k;
    int base;
    bit poked;
    busy_len = first ? 50 : int'($urandom_range(3, 12));
    base = pl_cnt;
    push_pass(first);
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    k = 0;
    while (!ifc.iic_pluse && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) begin
      timeout_fail("first_pluse");
      return;
    end
    n_chk++;
    if (k < int'(IDL) + 1 || k > int'(IDL) + 2) begin
      n_err++;
      $display("FAIL first_pluse_latency: actual %0d cycles, required %0d..%0d", k, IDL + 1, IDL + 2);
    end
    chk("busy_in_pass", 64'({cfg_busy, cfg_done}), 64'(2'b10));
    k = 0;
    poked = 1'b0;
    while (!cfg_done && k < 20000) begin
      @(negedge clk); k++;
      if (poke && !poked && ifc.iic_busy && !ifc.iic_pluse) begin
        cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        poked = 1'b1;
      end
      if (abort && pl_cnt >= base + XPE + 1 && ifc.iic_busy && !ifc.iic_pluse) begin
        rstn = 1'b0;
        @(negedge clk);
        chk_reset();
        sb_q.delete();
        rd_q.delete();
        exp_err_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        return;
      end
    end
    if (k >= 20000) begin
      timeout_fail("cfg_done");
      return;
    end
    chk("pluse_count", 64'(pl_cnt), 64'(base + int'(RN) * XPE));
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    chk("done_flags", 64'({cfg_busy, cfg_done, ifc.iic_busy}), 64'(3'b010));
    chk("last_idx", 64'(tbl_idx), 64'(RN - 8'd1));
`ifdef CFG_READBACK_EN
    chk("readback_err", 64'({cfg_err, err_cnt}), 64'({exp_err_cnt != 8'd0, exp_err_cnt}));
`endif
  endtask

  // Behavioural I2C driver for the main instance
  initial begin
    int n;
    bit rd;
    ifc.iic_busy      = 1'b0;
    ifc.iic_byte_over = 1'b0;
    ifc.iic_data_out  = 8'h00;
    forever begin
      @(negedge clk);
      if (rstn && ifc.iic_pluse && !ifc.iic_busy) begin
        rd = ~ifc.iic_w_r;
        n  = busy_len;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ifc.iic_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if (!rstn) break;
          if (rd && i == n - 2) begin
            ifc.iic_byte_over = 1'b1;
            if (rd_q.size() > 0) ifc.iic_data_out = rd_q.pop_front();
            else ifc.iic_data_out = 8'h00;
          end else begin
            ifc.iic_byte_over = 1'b0;
          end
        end
        ifc.iic_byte_over = 1'b0;
        ifc.iic_busy      = 1'b0;
      end
    end
  end

  // Minimal driver for the single-entry instance
  initial begin
    if1.iic_busy      = 1'b0;
    if1.iic_byte_over = 1'b0;
    if1.iic_data_out  = 8'hA5;
    forever begin
      @(negedge clk);
      if (rstn && if1.iic_pluse && !if1.iic_busy) begin
        p1_cnt++;
        if1.iic_busy = 1'b1;
        repeat (4) @(negedge clk);
        if1.iic_byte_over = 1'b1;
        @(negedge clk);
        if1.iic_byte_over = 1'b0;
        if1.iic_busy      = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every pluse rise and tracks stability and static flags
  initial begin
    xfer_t cur;
    logic  prev = 1'b0;
    bit    cur_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        prev      = 1'b0;
        cur_valid = 1'b0;
      end else begin
        if (ifc.iic_pluse && !prev) begin
          pl_cnt++;
          if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_pluse: actual idx %0d, required no transfer", tbl_idx);
            cur_valid = 1'b0;
          end else begin
            cur = sb_q.pop_front();
            chk("xfer", 64'({tbl_idx, ifc.iic_w_r, ifc.iic_addr, ifc.iic_data_in}), 64'(cur));
            cur_valid = 1'b1;
          end
        end else if ((ifc.iic_pluse || ifc.iic_busy) && cur_valid) begin
          if ({tbl_idx, ifc.iic_w_r, ifc.iic_addr, ifc.iic_data_in} != cur) stab_bad++;
        end
        prev = ifc.iic_pluse;
      end
`ifndef CFG_READBACK_EN
      if (ifc.iic_w_r !== 1'b1) wr_bad++;
      if (err_cnt !== 8'h00 || cfg_err !== 1'b0) err_bad++;
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int k;
    for (int i = 0; i < 256; i++) tbl_mem[i] = 16'h0000;
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'h3A04;
    tbl_mem[2] = 16'($urandom);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset();
    chk("device_id", 64'(ifc.iic_device_id), 64'(DID));
    chk("byte_len", 64'(ifc.iic_byte_len), 64'(4'd1));
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", 64'({tbl_idx, cfg_busy, ifc.iic_pluse}), 64'(10'd0));

    run_pass(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    run_pass(1'b0, 1'b1, 1'b0);
    run_pass(1'b0, 1'b0, 1'b0);
    run_pass(1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    run_pass(1'b0, 1'b0, 1'b0);

    p1_cnt = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    k = 0;
    while (!done1 && k < 2000) begin
      @(negedge clk); k++;
    end
    if (k >= 2000) timeout_fail("regnum1_done");
    else begin
      chk("regnum1_pulses", 64'(p1_cnt), 64'(XPE));
      chk("regnum1_state", 64'({tbl_idx1, busy1, err1, err_cnt1}), 64'(18'd0));
    end

    chk("stable_during_xfer", 64'(stab_bad), 64'(0));
`ifndef CFG_READBACK_EN
    chk("w_r_always_1", 64'(wr_bad), 64'(0));
    chk("err_always_0", 64'(err_bad), 64'(0));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
